// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: PC register, instruction-memory initiator and the IF/ID register.
// Handles stall, flush, delayed-branch redirect and exception redirect, and flags misaligned fetches.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  output logic        inst_ce,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_adel
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        misaligned;

  assign inst_addr  = pc;
  assign misaligned = (pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      inst_ce  <= 1'b0;
      id_pc    <= 32'h0;
      id_inst  <= 32'h0;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= RUN;
          inst_ce  <= 1'b1;
          id_pc    <= pc;
          id_inst  <= 32'h0;
          id_valid <= 1'b0;
          id_adel  <= 1'b0;
        end
        RUN: begin
          inst_ce <= 1'b1;
          // A taken branch does not squash the current fetch: that is the delay slot.
          if (exc_req)           pc <= exc_pc;
          else if (stall)        pc <= pc;
          else if (branch_taken) pc <= branch_target;
          else                   pc <= pc + 32'd4;

          if (exc_req || flush) begin
            id_pc    <= pc;
            id_inst  <= 32'h0;
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
          end else if (!stall) begin
            id_pc    <= pc;
            id_valid <= 1'b1;
            id_inst  <= misaligned ? 32'h0 : inst_data;
            id_adel  <= misaligned;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a reference model pushes the expected IF/ID contents each cycle into a
// scoreboard queue, popped and compared after the edge, plus directed checks of the key scenarios.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] W_A = 32'hAAAA_0001, W_B = 32'hBBBB_0002,
                          W_C = 32'hCCCC_0003, W_D = 32'hDDDD_0004;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        adel;
  } id_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_taken, exc_req;
  logic [31:0] branch_target, exc_pc;
  logic        inst_ce;
  logic [31:0] inst_addr, inst_data;
  logic [31:0] id_pc, id_inst;
  logic        id_valid, id_adel;

  int errors = 0;
  int checks = 0;

  id_t         sb[$];
  id_t         m_id;
  logic [31:0] m_pc;
  logic        m_ce;
  logic        seen28;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .exc_req(exc_req), .exc_pc(exc_pc),
    .inst_ce(inst_ce), .inst_addr(inst_addr), .inst_data(inst_data),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_adel(id_adel)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    case (a[31:2])
      30'd0:   memw = W_A;
      30'd1:   memw = W_B;
      30'd2:   memw = W_C;
      30'd3:   memw = W_D;
      default: memw = {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endcase
  endfunction

  assign inst_data = inst_ce ? memw(inst_addr) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: model the edge from current inputs, push expectation, compare after the edge.
  task automatic tick();
    id_t         e, g;
    logic [31:0] npc;
    logic        nce;
    e = m_id; npc = m_pc; nce = m_ce;
    if (rst) begin
      e = '0; npc = RESET_PC; nce = 1'b0;
    end else if (!m_ce) begin
      e = '{pc: m_pc, inst: 32'h0, valid: 1'b0, adel: 1'b0}; nce = 1'b1;
    end else begin
      if (exc_req)           npc = exc_pc;
      else if (stall)        npc = m_pc;
      else if (branch_taken) npc = branch_target;
      else                   npc = m_pc + 32'd4;
      if (exc_req || flush)
        e = '{pc: m_pc, inst: 32'h0, valid: 1'b0, adel: 1'b0};
      else if (!stall) begin
        e.pc = m_pc; e.valid = 1'b1; e.adel = (m_pc[1:0] != 2'b00);
        e.inst = e.adel ? 32'h0 : memw(m_pc);
      end
    end
    sb.push_back(e);
    @(posedge clk);
    m_pc = npc; m_ce = nce; m_id = e;
    #1;
    g = sb.pop_front();
    chk("inst_addr", inst_addr, m_pc);
    chk("inst_ce", {31'h0, inst_ce}, {31'h0, m_ce});
    chk("id_valid", {31'h0, id_valid}, {31'h0, g.valid});
    chk("id_adel", {31'h0, id_adel}, {31'h0, g.adel});
    chk("id_inst", id_inst, g.inst);
    if (g.valid || rst) chk("id_pc", id_pc, g.pc);
    if (inst_ce && inst_addr == 32'h28) seen28 = 1'b1;
  endtask

  task automatic idle_in();
    stall = 0; flush = 0; branch_taken = 0; exc_req = 0;
    branch_target = 32'h0; exc_pc = 32'h0;
  endtask

  initial begin
    int n;
    m_pc = 32'h0; m_ce = 1'b0; m_id = '0; seen28 = 1'b0;
    idle_in();
    rst = 1;
    tick(); tick();
    chk("rst_ce", {31'h0, inst_ce}, 32'h0);
    chk("rst_pc", inst_addr, RESET_PC);
    chk("rst_idpc", id_pc, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);

    // sequential fetch from reset
    rst = 0;
    tick();
    chk("first_ce", {31'h0, inst_ce}, 32'h1);
    chk("first_addr", inst_addr, 32'h0);
    chk("first_bubble", {31'h0, id_valid}, 32'h0);
    tick(); chk("seq_A", id_inst, W_A); chk("seq_a4", inst_addr, 32'h4);
    tick(); chk("seq_B", id_inst, W_B); chk("seq_a8", inst_addr, 32'h8);
    tick(); chk("seq_C", id_inst, W_C); chk("seq_aC", inst_addr, 32'hC);
    tick(); chk("seq_D", id_inst, W_D); chk("seq_a10", inst_addr, 32'h10);

    // 3-cycle stall at 0x10
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", inst_addr, 32'h10);
      chk("stall_idpc", id_pc, 32'hC);
    end
    stall = 0;
    tick(); chk("unstall_idpc", id_pc, 32'h10); chk("unstall_addr", inst_addr, 32'h14);
    flush = 1;
    tick(); chk("flush_bubble", {31'h0, id_valid}, 32'h0);
    flush = 0;
    tick(); chk("post_flush_valid", {31'h0, id_valid}, 32'h1);

    // branch with delay slot at 0x24
    seen28 = 1'b0;
    n = 0;
    while (inst_addr != 32'h24 && n < 20) begin tick(); n++; end
    chk("reach_24", inst_addr, 32'h24);
    branch_taken = 1; branch_target = 32'h40;
    tick(); chk("dslot_idpc", id_pc, 32'h24); chk("br_addr", inst_addr, 32'h40);
    idle_in();
    tick(); chk("target_idpc", id_pc, 32'h40);
    tick();
    chk("no_fetch_28", {31'h0, seen28}, 32'h0);

    // exception beats branch and stall
    exc_req = 1; exc_pc = 32'h180; branch_taken = 1; branch_target = 32'h40; stall = 1;
    tick(); chk("exc_addr", inst_addr, 32'h180); chk("exc_bubble", {31'h0, id_valid}, 32'h0);
    idle_in();
    tick(); chk("exc_idpc", id_pc, 32'h180);

    // misaligned redirect
    branch_taken = 1; branch_target = 32'h42;
    tick(); idle_in();
    tick();
    chk("adel_flag", {31'h0, id_adel}, 32'h1);
    chk("adel_inst", id_inst, 32'h0);
    chk("adel_idpc", id_pc, 32'h42);
    chk("adel_next", inst_addr, 32'h46);

    // wrap at top of address space
    branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    tick(); idle_in();
    tick(); chk("wrap_addr", inst_addr, 32'h0);

    // mid-run reset at pc 0x30
    branch_taken = 1; branch_target = 32'h30;
    tick(); idle_in();
    chk("pre_rst_pc", inst_addr, 32'h30);
    rst = 1;
    tick();
    chk("mrst_ce", {31'h0, inst_ce}, 32'h0);
    chk("mrst_addr", inst_addr, RESET_PC);
    chk("mrst_idpc", id_pc, 32'h0);
    chk("mrst_inst", id_inst, 32'h0);
    chk("mrst_valid", {31'h0, id_valid}, 32'h0);
    chk("mrst_adel", {31'h0, id_adel}, 32'h0);
    rst = 0;
    tick(); chk("mrst_idle_valid", {31'h0, id_valid}, 32'h0);
    tick(); chk("mrst_A", id_inst, W_A);

    // random mix against the model
    for (int i = 0; i < 200; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 5) == 0);
      branch_taken  = ($urandom_range(0, 4) == 0);
      branch_target = {22'h0, $urandom_range(0, 255), 2'b00} | {30'h0, 2'($urandom_range(0, 7) == 0)};
      exc_req       = ($urandom_range(0, 15) == 0);
      exc_pc        = 32'h180;
      rst           = ($urandom_range(0, 40) == 0);
      tick();
    end
    idle_in(); rst = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the MIPS pipeline, and the initiator side of the instruction-memory interface. Holds the PC and drives the memory chip-enable and byte address. Captures the combinationally returned instruction word into the IF/ID pipeline register. Applies stall, flush, branch redirect (with architectural delay slot) and exception redirect, and flags misaligned fetch addresses to the decode stage.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  hold PC and IF/ID (downstream hazard).
- flush  in  1  load a bubble into IF/ID.
- branch_taken  in  1  redirect request from ID (branch/jump resolved).
- branch_target  in  32  redirect byte address.
- exc_req  in  1  exception redirect request; highest priority.
- exc_pc  in  32  exception vector byte address.
- inst_ce  out  1  instruction memory chip enable.
- inst_addr  out  32  instruction memory byte address; equals PC.
- inst_data  in  32  instruction word, valid in the same cycle as inst_addr (combinational memory; returns 0 when inst_ce=0).
- id_pc  out  32  PC of the instruction in IF/ID.
- id_inst  out  32  instruction in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction.
- id_adel  out  1  IF/ID instruction came from a misaligned PC (address-error-on-load, fetch).

## Operation

- Two-state FSM: IDLE (inst_ce=0), RUN (inst_ce=1). rst forces IDLE. IDLE→RUN on the first clock with rst=0. RUN stays in RUN until rst. No other transitions.
- Reset values (the cycle after rst is sampled high): pc=RESET_PC, inst_ce=0, id_pc=0, id_inst=0, id_valid=0, id_adel=0. Reset mid-operation discards all in-flight state identically.
- inst_addr = pc, driven directly from the register. inst_ce is registered.
- In IDLE, the PC does not advance and IF/ID loads a bubble.
- Next-PC in RUN, in priority order:
  - exc_req=1 → exc_pc. This overrides stall.
  - stall=1 → pc (hold). branch_taken is ignored while stalled, because ID holds the branch and reasserts it.
  - branch_taken=1 → branch_target.
  - otherwise → pc+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Delay slot: a branch_taken does not squash the instruction currently being fetched. That instruction (the delay slot) enters IF/ID normally.
- IF/ID update in RUN, in priority order:
  - exc_req or flush → bubble: id_valid=0, id_inst=0, id_adel=0. id_pc takes the current pc.
  - stall → hold all id_* outputs.
  - otherwise → id_pc=pc, id_valid=1. If pc[1:0]==0: id_inst=inst_data, id_adel=0. If pc[1:0]!=0: id_inst=0 (nop), id_adel=1.
- Misaligned PC: the fetch still proceeds and the PC still advances by +4. Misalignment persists until a redirect. Decode/exception logic is responsible for raising exc_req.
- flush and stall together: flush wins for IF/ID. The PC holds unless exc_req is also set.

## Timing

- Fetch latency is 1 cycle. The PC presented in cycle n appears on id_pc/id_inst after edge n.
- First fetch: rst deasserted before edge k gives inst_ce=1 after edge k. The instruction at RESET_PC reaches IF/ID after edge k+1.
- Branch: branch_taken is sampled at edge n while the branch sits in ID and its delay slot is in IF.
  - Delay slot enters ID after edge n.
  - pc=branch_target after edge n.
  - Target instruction enters ID after edge n+1.
- Exception: exc_req sampled at edge n gives pc=exc_pc and a bubble in IF/ID after edge n. The vector instruction is in ID after edge n+1.
- Stall of m cycles: PC and IF/ID are frozen for exactly m edges. No instruction is lost or duplicated.

## Test plan

- Reset/sequential fetch: RESET_PC=0, memory words 0..3 = A,B,C,D, release rst.
  - One IDLE cycle, then inst_addr = 0,4,8,C on successive cycles.
  - id_inst = A,B,C,D one cycle later, each with id_valid=1.
- Branch with delay slot: branch_taken=1, target=0x40 in the cycle inst_addr=0x24.
  - id_pc sequence ends 0x24, 0x40.
  - Instruction at 0x24 is not dropped.
  - 0x28 is never fetched.
- Stall/flush: assert stall for 3 cycles at inst_addr=0x10.
  - inst_addr stays 0x10 and id_* hold.
  - Release: fetch resumes at 0x14 with no duplicate id_pc.
  - Then flush for 1 cycle: id_valid=0 for exactly that cycle.
- Priority: exc_req=1 (exc_pc=0x180) together with branch_taken=1 (target 0x40) and stall=1.
  - Next inst_addr=0x180; IF/ID bubble.
  - Next cycle id_pc=0x180.
- Misalignment and wrap:
  - branch_target=0x42 → id_adel=1, id_inst=0, id_pc=0x42; next inst_addr=0x46.
  - Separately, PC at 0xFFFF_FFFC with no redirect → next inst_addr=0x0000_0000.
- Mid-run reset: assert rst for 1 cycle while in RUN at pc=0x30.
  - All outputs return to reset values.
  - Fetch restarts at RESET_PC after one IDLE cycle.
